// File: rtl/booth_seq_mul_if.sv
// Handshake and operand/result bundle for the sequential Booth multiplier.
// The master (control unit) drives the request and operands; the slave
// (the multiplier) returns status and the registered product.
interface booth_seq_mul_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               is_signed;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   r;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] c_ans;
  logic [WIDTH-1:0]   ans;
  logic               overflow;

  modport master (
    output start, is_signed, m, r,
    input  busy, done, c_ans, ans, overflow
  );

  modport slave (
    input  start, is_signed, m, r,
    output busy, done, c_ans, ans, overflow
  );
endinterface

// File: rtl/booth_seq_mul.sv
// Sequential radix-4 Booth multiplier: one recoded digit per clock,
// WIDTH/2+1 steps per product, full 2*WIDTH-bit result plus a low-word
// overflow flag that follows the signed/unsigned mode of the request.
module booth_seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  booth_seq_mul_if.slave  bus
);
  localparam int ITER = WIDTH / 2 + 1;
  localparam int XW   = WIDTH + 2;          // extended operand width
  localparam int AW   = 2 * WIDTH + 4;      // accumulator width
  localparam int CW   = $clog2(ITER + 1);

  localparam logic [AW-1:0] ACC_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] ACC_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Booth partial product for one digit; m_sh already carries the 4^i weight.
  function automatic logic [AW-1:0] f_booth_pp(input logic [2:0] triple,
                                               input logic [AW-1:0] m_sh);
    logic [AW-1:0] m2;
    m2 = {m_sh[AW-2:0], 1'b0};
    case (triple)
      3'b000, 3'b111: f_booth_pp = ACC_ZERO;
      3'b001, 3'b010: f_booth_pp = m_sh;
      3'b011:         f_booth_pp = m2;
      3'b100:         f_booth_pp = ~m2 + ACC_ONE;
      3'b101, 3'b110: f_booth_pp = ~m_sh + ACC_ONE;
      default:        f_booth_pp = ACC_ZERO;
    endcase
  endfunction

  // Low-word overflow: signed needs the top WIDTH+1 bits to be a pure sign
  // extension, unsigned needs the high word to be zero.
  function automatic logic f_overflow(input logic [2*WIDTH-1:0] prod,
                                      input logic sgn);
    logic [WIDTH:0] hi;
    hi = prod[2*WIDTH-1:WIDTH-1];
    if (sgn) begin
      f_overflow = !((&hi) || !(|hi));
    end else begin
      f_overflow = |prod[2*WIDTH-1:WIDTH];
    end
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_last;
  logic [CW-1:0]      r_cnt;
  logic [AW-1:0]      r_m_sh;               // multiplicand, pre-shifted by 4^i
  logic [XW:0]        r_rx;                 // {multiplier, 1'b0}, consumed 2 bits/step
  logic [AW-1:0]      r_acc;
  logic               r_sign;
  logic               r_busy;
  logic               r_done;
  logic [2*WIDTH-1:0] r_c_ans;
  logic               r_ovf;

  logic [XW-1:0]      w_m_ext;
  logic [XW-1:0]      w_r_ext;
  logic [AW-1:0]      w_m_full;
  logic [AW-1:0]      w_acc_nxt;

  assign w_m_ext   = {{2{bus.is_signed & bus.m[WIDTH-1]}}, bus.m};
  assign w_r_ext   = {{2{bus.is_signed & bus.r[WIDTH-1]}}, bus.r};
  assign w_m_full  = {{(AW-XW){w_m_ext[XW-1]}}, w_m_ext};
  assign w_acc_nxt = r_acc + f_booth_pp(r_rx[2:0], r_m_sh);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: accept a request only in IDLE, leave RUN after the last digit.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_cnt == CNT_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: latch operands on accept, add one Booth digit per RUN cycle,
  // register the product and pulse done on the final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= {CW{1'b0}};
      r_m_sh  <= ACC_ZERO;
      r_rx    <= {(XW+1){1'b0}};
      r_acc   <= ACC_ZERO;
      r_sign  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_c_ans <= {(2*WIDTH){1'b0}};
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_cnt  <= {CW{1'b0}};
      r_m_sh <= w_m_full;
      r_rx   <= {w_r_ext, 1'b0};
      r_acc  <= ACC_ZERO;
      r_sign <= bus.is_signed;
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_cnt  <= r_cnt + CNT_ONE;
      r_m_sh <= {r_m_sh[AW-3:0], 2'b00};
      r_rx   <= {2'b00, r_rx[XW:2]};
      r_acc  <= w_acc_nxt;
      if (w_last) begin
        r_c_ans <= w_acc_nxt[2*WIDTH-1:0];
        r_ovf   <= f_overflow(w_acc_nxt[2*WIDTH-1:0], r_sign);
        r_done  <= 1'b1;
        r_busy  <= 1'b0;
      end else begin
        r_done  <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.c_ans    = r_c_ans;
  assign bus.ans      = r_c_ans[WIDTH-1:0];
  assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_booth_seq_mul.sv
// Self-checking bench for booth_seq_mul: directed test-plan cases plus
// randomized regression at WIDTH=32 and WIDTH=8 against an arithmetic model.
module tb_booth_seq_mul;
  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  booth_seq_mul_if #(.WIDTH(32)) bus32 ();
  booth_seq_mul_if #(.WIDTH(8))  bus8 ();

  booth_seq_mul #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  booth_seq_mul #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer multiplication in the requested mode.
  function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint x;
    longint y;
    x = s ? longint'($signed(a)) : longint'({32'd0, a});
    y = s ? longint'($signed(b)) : longint'({32'd0, b});
    return 64'(x * y);
  endfunction

  function automatic logic ovf32(input logic [63:0] p, input logic s);
    if (s) return ($signed(p) < -64'sd2147483648) || ($signed(p) > 64'sd2147483647);
    else   return p[63:32] != 32'd0;
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int x;
    int y;
    x = s ? int'($signed(a)) : int'({24'd0, a});
    y = s ? int'($signed(b)) : int'({24'd0, b});
    return 16'(x * y);
  endfunction

  function automatic logic ovf8(input logic [15:0] p, input logic s);
    if (s) return (int'($signed(p)) < -128) || (int'($signed(p)) > 127);
    else   return p[15:8] != 8'd0;
  endfunction

  function automatic logic [31:0] pick32();
    logic [31:0] c [6];
    c = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
    if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  function automatic logic [7:0] pick8();
    logic [7:0] c [6];
    c = '{8'h00, 8'h01, 8'hFF, 8'h80, 8'h7F, 8'hFE};
    if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 5)];
    return 8'($urandom);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One complete 32-bit multiply; entered and left 1 time unit after a rising edge.
  task automatic mul32(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] ep;
    int lat;
    ep = ref32(a, b, s);
    bus32.m = a; bus32.r = b; bus32.is_signed = s; bus32.start = 1'b1;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    chk("busy32", 64'(bus32.busy), 64'd1);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus32.done) begin lat = k; break; end
    end
    chk("latency32", 64'(lat), 64'd17);
    chk("c_ans32", bus32.c_ans, ep);
    chk("ans32", 64'(bus32.ans), 64'(ep[31:0]));
    chk("ovf32", 64'(bus32.overflow), 64'(ovf32(ep, s)));
    chk("busy_at_done32", 64'(bus32.busy), 64'd0);
    @(posedge clk); #1;
    chk("done_pulse32", 64'(bus32.done), 64'd0);
  endtask

  task automatic mul8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [15:0] ep;
    int lat;
    ep = ref8(a, b, s);
    bus8.m = a; bus8.r = b; bus8.is_signed = s; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus8.done) begin lat = k; break; end
    end
    chk("latency8", 64'(lat), 64'd5);
    chk("c_ans8", 64'(bus8.c_ans), 64'(ep));
    chk("ans8", 64'(bus8.ans), 64'(ep[7:0]));
    chk("ovf8", 64'(bus8.overflow), 64'(ovf8(ep, s)));
  endtask

  initial begin
    int dones;
    int lat;
    n_pass = 0; n_total = 0;
    rst_n = 1'b0;
    bus32.start = 1'b0; bus32.is_signed = 1'b0; bus32.m = '0; bus32.r = '0;
    bus8.start  = 1'b0; bus8.is_signed  = 1'b0; bus8.m  = '0; bus8.r  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus32.busy), 64'd0);
    chk("rst_done", 64'(bus32.done), 64'd0);
    chk("rst_c_ans", bus32.c_ans, 64'd0);
    chk("rst_ovf", 64'(bus32.overflow), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed test-plan products.
    mul32(32'h0000_0003, 32'hFFFF_FFF9, 1'b1);
    chk("dir_3x-7", bus32.c_ans, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("dir_3x-7_ans", 64'(bus32.ans), 64'h0000_0000_FFFF_FFEB);
    mul32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("dir_umax", bus32.c_ans, 64'hFFFF_FFFE_0000_0001);
    chk("dir_umax_ovf", 64'(bus32.overflow), 64'd1);
    mul32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    chk("dir_smax", bus32.c_ans, 64'd1);
    chk("dir_smax_ovf", 64'(bus32.overflow), 64'd0);
    mul32(32'h8000_0000, 32'h8000_0000, 1'b1);
    chk("dir_minmin", bus32.c_ans, 64'h4000_0000_0000_0000);
    chk("dir_minmin_ovf", 64'(bus32.overflow), 64'd1);
    mul32(32'h8000_0000, 32'h0000_0001, 1'b1);
    chk("dir_minx1", bus32.c_ans, 64'hFFFF_FFFF_8000_0000);
    chk("dir_minx1_ovf", 64'(bus32.overflow), 64'd0);

    // Start re-asserted while busy is ignored; start in the done cycle is accepted.
    bus32.m = 32'h0000_0003; bus32.r = 32'hFFFF_FFF9; bus32.is_signed = 1'b1; bus32.start = 1'b1;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    dones = 0; lat = 0;
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk); #1;
      if (bus32.done) begin dones++; lat = k; end
      if (k >= 2 && k <= 9) begin
        bus32.start = 1'b1; bus32.m = 32'h1234_5678; bus32.r = 32'h0000_0009; bus32.is_signed = 1'b0;
      end else begin
        bus32.start = 1'b0;
      end
    end
    chk("ign_dones", 64'(dones), 64'd1);
    chk("ign_latency", 64'(lat), 64'd17);
    chk("ign_c_ans", bus32.c_ans, 64'hFFFF_FFFF_FFFF_FFEB);
    bus32.m = 32'h8000_0000; bus32.r = 32'h0000_0001; bus32.is_signed = 1'b1; bus32.start = 1'b1;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    chk("b2b_busy", 64'(bus32.busy), 64'd1);
    chk("b2b_done_low", 64'(bus32.done), 64'd0);
    chk("b2b_held", bus32.c_ans, 64'hFFFF_FFFF_FFFF_FFEB);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus32.done) begin lat = k; break; end
    end
    chk("b2b_latency", 64'(lat), 64'd17);
    chk("b2b_c_ans", bus32.c_ans, 64'hFFFF_FFFF_8000_0000);

    // Reset during RUN discards the operation immediately.
    bus32.m = 32'h0000_0007; bus32.r = 32'h0000_0005; bus32.is_signed = 1'b0; bus32.start = 1'b1;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(bus32.busy), 64'd0);
    chk("mid_rst_done", 64'(bus32.done), 64'd0);
    chk("mid_rst_c_ans", bus32.c_ans, 64'd0);
    chk("mid_rst_ovf", 64'(bus32.overflow), 64'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (bus32.done || bus32.busy) dones++;
    end
    chk("mid_rst_no_done", 64'(dones), 64'd0);
    mul32(32'h0000_0007, 32'h0000_0005, 1'b0);

    // Randomized regression, both widths and both modes.
    for (int i = 0; i < 1500; i++) begin
      mul32(pick32(), pick32(), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 4000; i++) begin
      mul8(pick8(), pick8(), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
